frame_capture_160x120: RTL

Receiving end of the full-screen pixel stream emitted by the screen drawers (x, y, colour plus a level "done" flag). Writes each in-range pixel into an internal 160x120x9 frame store. Tracks frame completeness and errors. Provides a random-access read port, so screens drawn by any drawer can be captured and read back for verification, or stored and replayed.

---
 rtl/frame_capture_160x120_pkg.sv | 27 ++
 rtl/framebuffer_ram_19200x9.sv | 23 ++
 rtl/frame_capture_160x120.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/frame_capture_160x120_pkg.sv
// Shared constants, capture state enum and frame-store address helper for the
// 160x120 screen drawers and the frame capture block.
package frame_capture_160x120_pkg;

  localparam int unsigned FB_W      = 160;
  localparam int unsigned FB_H      = 120;
  localparam int unsigned FB_PIXELS = 19200;
  localparam int unsigned FB_AW     = 15;
  localparam int unsigned COLOUR_W  = 9;
  localparam int unsigned X_W       = 8;
  localparam int unsigned Y_W       = 7;
  localparam int unsigned CNT_W     = 15;
  localparam int unsigned CS_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } cap_state_t;

  // y*160 + x without a multiplier
  function automatic logic [FB_AW-1:0] fb_addr(input logic [X_W-1:0] x,
                                               input logic [Y_W-1:0] y);
    return (FB_AW'(y) << 7) + (FB_AW'(y) << 5) + FB_AW'(x);
  endfunction

endpackage

// File: rtl/framebuffer_ram_19200x9.sv
// Simple dual-port frame store: one write port, one registered read port,
// read-before-write on a same-address collision.
module framebuffer_ram_19200x9
  import frame_capture_160x120_pkg::*;
(
  input  logic                clk,
  input  logic                wr_en,
  input  logic [FB_AW-1:0]    wr_addr,
  input  logic [COLOUR_W-1:0] wr_data,
  input  logic                rd_en,
  input  logic [FB_AW-1:0]    rd_addr,
  output logic [COLOUR_W-1:0] rd_data
);

  logic [COLOUR_W-1:0] mem [FB_PIXELS];

  // Non-blocking write makes a same-cycle read see the old word
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frame_capture_160x120.sv
// Captures a full-screen pixel stream into a 160x120x9 frame store and tracks
// frame completeness/errors. Optional FRAME_CAPTURE_CHECKSUM_EN adds a checksum.
module frame_capture_160x120
  import frame_capture_160x120_pkg::*;
#(
  parameter int unsigned FB_W   = 160,
  parameter int unsigned FB_H   = 120,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                pix_valid,
  input  logic [X_W-1:0]      pix_x,
  input  logic [Y_W-1:0]      pix_y,
  input  logic [COLOUR_W-1:0] pix_colour,
  input  logic                src_done,
  output logic                capturing,
  output logic                frame_complete,
  output logic [CNT_W-1:0]    pix_count,
  output logic                err_oob,
  output logic                err_short,
  input  logic                rd_req,
  input  logic [X_W-1:0]      rd_x,
  input  logic [Y_W-1:0]      rd_y,
  output logic [COLOUR_W-1:0] rd_colour,
`ifdef FRAME_CAPTURE_CHECKSUM_EN
  output logic [CS_W-1:0]     checksum,
`endif
  output logic                rd_valid
);

  if (RD_LAT != 2) begin : g_rd_lat_check
    $error("frame_capture_160x120: RD_LAT is fixed at 2");
  end

  cap_state_t          state, state_nxt;
  logic                src_done_q;
  logic                done_rise;
  logic                pix_in_range;
  logic                start_pix;
  logic                wr_en_c;
  logic [FB_AW-1:0]    wr_addr_c;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                oob_nxt;
  logic                short_nxt;
  logic                rd_in_range;
  logic [FB_AW-1:0]    rd_addr_c;
  logic [COLOUR_W-1:0] ram_q;
  logic                rd_v1;
  logic                rd_oob1;

  assign done_rise    = src_done && !src_done_q;
  assign pix_in_range = (pix_x < X_W'(FB_W)) && (pix_y < Y_W'(FB_H));
  assign start_pix    = pix_valid && (pix_x == '0) && (pix_y == '0);
  assign wr_addr_c    = pix_in_range ? fb_addr(pix_x, pix_y) : '0;
  assign rd_in_range  = (rd_x < X_W'(FB_W)) && (rd_y < Y_W'(FB_H));
  assign rd_addr_c    = rd_in_range ? fb_addr(rd_x, rd_y) : '0;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state, write strobe and next status values
  always_comb begin
    state_nxt = state;
    cnt_nxt   = pix_count;
    oob_nxt   = err_oob;
    short_nxt = err_short;
    wr_en_c   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_pix) begin
          state_nxt = CAPTURE;
          cnt_nxt   = CNT_W'(1);
          oob_nxt   = 1'b0;
          short_nxt = 1'b0;
          wr_en_c   = 1'b1;
        end
      end
      CAPTURE: begin
        if (pix_valid) begin
          if (pix_in_range) begin
            wr_en_c = 1'b1;
            if (pix_count != '1) cnt_nxt = pix_count + CNT_W'(1);
          end else begin
            oob_nxt = 1'b1;
          end
        end
        // Short check sees a pixel accepted in the same cycle as the edge
        if (done_rise) begin
          state_nxt = DONE;
          if (cnt_nxt != CNT_W'(FB_PIXELS)) short_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      src_done_q     <= 1'b0;
      pix_count      <= '0;
      err_oob        <= 1'b0;
      err_short      <= 1'b0;
      capturing      <= 1'b0;
      frame_complete <= 1'b0;
    end else begin
      src_done_q     <= src_done;
      pix_count      <= cnt_nxt;
      err_oob        <= oob_nxt;
      err_short      <= short_nxt;
      capturing      <= (state_nxt == CAPTURE);
      frame_complete <= (state_nxt == DONE) && !oob_nxt && !short_nxt;
    end
  end

`ifdef FRAME_CAPTURE_CHECKSUM_EN
  // Start pixel reloads the sum; only CAPTURE writes accumulate
  always_ff @(posedge clk) begin
    if (!resetn) begin
      checksum <= '0;
    end else if (wr_en_c) begin
      checksum <= (state == CAPTURE) ? checksum + CS_W'(pix_colour)
                                     : CS_W'(pix_colour);
    end
  end
`endif

  framebuffer_ram_19200x9 u_ram (
    .clk     (clk),
    .wr_en   (wr_en_c),
    .wr_addr (wr_addr_c),
    .wr_data (pix_colour),
    .rd_en   (rd_req),
    .rd_addr (rd_addr_c),
    .rd_data (ram_q)
  );

  // Read pipeline: stage 1 is the RAM register, stage 2 the output register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_v1     <= 1'b0;
      rd_oob1   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_colour <= '0;
    end else begin
      rd_v1    <= rd_req;
      rd_oob1  <= !rd_in_range;
      rd_valid <= rd_v1;
      if (rd_v1) rd_colour <= rd_oob1 ? '0 : ram_q;
    end
  end

endmodule
